// File: rtl/controlador_busqueda.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_busqueda
//  Description : Instruction-fetch sequencer between a byte-wide instruction
//                memory and the decode stage. Owns the program counter,
//                reads four consecutive bytes (wrapping modulo 2^ANCHO_DIR),
//                assembles a big-endian 32-bit word (byte at pc -> [31:24])
//                and offers it to decode over a valid/ready handshake.
//                Redirect requests (salto_en) abort any fetch in progress
//                and have priority over every other action.
//
//  Parameters  : ANCHO_DIR  - width of pc and of the memory byte address
//                PC_INICIAL - pc value loaded on reset
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                habilitar  - run enable, sampled only in B0
//                salto_en   - redirect request
//                salto_dir  - redirect target byte address
//                mem_dir    - byte address to instruction memory
//                mem_dato   - byte returned combinationally for mem_dir
//                inst       - assembled instruction
//                inst_pc    - byte address of inst's first byte
//                inst_valid - inst/inst_pc valid
//                inst_ready - decode accepts inst
//                ocupado    - high while in B1..B3 or VAL
//                error_alin - sticky misaligned-redirect flag
//
//  Build option: CTRL_ALIGN_CHECK_EN
//                defined   -> a redirect whose target has bits [1:0] != 0
//                             sets error_alin and halts fetching until reset
//                undefined -> error_alin is tied 0 and unaligned targets
//                             are fetched byte by byte like any other
//
//  Revision    : 1.0 - initial release
// ============================================================================

module controlador_busqueda #(
    parameter int                   ANCHO_DIR  = 8,
    parameter logic [ANCHO_DIR-1:0] PC_INICIAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 habilitar,
    input  logic                 salto_en,
    input  logic [ANCHO_DIR-1:0] salto_dir,
    output logic [ANCHO_DIR-1:0] mem_dir,
    input  logic [7:0]           mem_dato,
    output logic [31:0]          inst,
    output logic [ANCHO_DIR-1:0] inst_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 ocupado,
    output logic                 error_alin
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_B0  = 3'd0,
        ST_B1  = 3'd1,
        ST_B2  = 3'd2,
        ST_B3  = 3'd3,
        ST_VAL = 3'd4
    } estado_t;

    localparam logic [ANCHO_DIR-1:0] c_PASO_INST = ANCHO_DIR'(4);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    estado_t              r_estado;
    logic [ANCHO_DIR-1:0] r_pc;
    logic [23:0]          r_acum;       // first three bytes, shifted in MSB-first
    logic [31:0]          r_inst;
    logic [ANCHO_DIR-1:0] r_inst_pc;
    logic                 r_inst_valid;
    logic                 r_ocupado;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [ANCHO_DIR-1:0] w_desp;       // byte offset of the current state
    logic                 w_bloqueado;  // fetch halted after a bad redirect

    // Memory address depends on registered state only: the low state bits
    // of B0..B3 are exactly the byte offset, VAL parks on pc.
    always_comb begin
        w_desp = '0;
        case (r_estado)
            ST_B0:   w_desp = ANCHO_DIR'(0);
            ST_B1:   w_desp = ANCHO_DIR'(1);
            ST_B2:   w_desp = ANCHO_DIR'(2);
            ST_B3:   w_desp = ANCHO_DIR'(3);
            default: w_desp = '0;
        endcase
    end

    // Natural truncation of the sum gives the modulo-2^ANCHO_DIR wrap.
    assign mem_dir = r_pc + w_desp;

`ifdef CTRL_ALIGN_CHECK_EN
    // ------------------------------------------------------------------------
    // Misaligned-redirect detection: sticky until reset, and while set the
    // sequencer refuses to leave B0.
    // ------------------------------------------------------------------------
    logic r_error_alin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error_alin <= 1'b0;
        end else if (salto_en && (salto_dir[1:0] != 2'b00)) begin
            r_error_alin <= 1'b1;
        end
    end

    assign w_bloqueado = r_error_alin;
    assign error_alin  = r_error_alin;
`else
    assign w_bloqueado = 1'b0;
    assign error_alin  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= ST_B0;
            r_pc         <= PC_INICIAL;
            r_acum       <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_ocupado    <= 1'b0;
        end else if (salto_en) begin
            // Redirect wins in every state. A coincident VAL handshake is
            // simply absorbed: the word is dropped from the interface and pc
            // takes the target instead of pc+4. Partial bytes are discarded.
            r_estado     <= ST_B0;
            r_pc         <= salto_dir;
            r_acum       <= '0;
            r_inst_valid <= 1'b0;
            r_ocupado    <= 1'b0;
        end else begin
            case (r_estado)
                ST_B0: begin
                    if (habilitar && !w_bloqueado) begin
                        r_acum    <= {r_acum[15:0], mem_dato};
                        r_estado  <= ST_B1;
                        r_ocupado <= 1'b1;
                    end
                end

                ST_B1: begin
                    r_acum   <= {r_acum[15:0], mem_dato};
                    r_estado <= ST_B2;
                end

                ST_B2: begin
                    r_acum   <= {r_acum[15:0], mem_dato};
                    r_estado <= ST_B3;
                end

                ST_B3: begin
                    // Last byte goes straight into the output word, so the
                    // instruction is visible on the same edge that enters VAL.
                    r_inst       <= {r_acum, mem_dato};
                    r_inst_pc    <= r_pc;
                    r_inst_valid <= 1'b1;
                    r_estado     <= ST_VAL;
                end

                ST_VAL: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= r_pc + c_PASO_INST;
                        r_estado     <= ST_B0;
                        r_ocupado    <= 1'b0;
                    end
                end

                default: begin
                    r_estado     <= ST_B0;
                    r_inst_valid <= 1'b0;
                    r_ocupado    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign ocupado    = r_ocupado;

endmodule

`default_nettype wire

// File: tb/tb_controlador_busqueda.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controlador_busqueda
//  Description : Directed self-checking bench for controlador_busqueda.
//                A byte-array memory model answers mem_dir combinationally;
//                expected instructions are queued when a fetch is started
//                and popped when the sequencer raises inst_valid.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_controlador_busqueda;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  pc;
    } esperado_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        habilitar  = 1'b0;
    logic        salto_en   = 1'b0;
    logic [7:0]  salto_dir  = 8'h00;
    logic        inst_ready = 1'b0;
    logic [7:0]  mem_dir;
    logic [7:0]  mem_dato;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        ocupado;
    logic        error_alin;

    logic [7:0]  mem [0:255];
    esperado_t   cola [$];

    int n_checks = 0;
    int n_err    = 0;

    assign mem_dato = mem[mem_dir];

    always #5 clk = ~clk;

    controlador_busqueda #(
        .ANCHO_DIR  (8),
        .PC_INICIAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .habilitar  (habilitar),
        .salto_en   (salto_en),
        .salto_dir  (salto_dir),
        .mem_dir    (mem_dir),
        .mem_dato   (mem_dato),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .ocupado    (ocupado),
        .error_alin (error_alin)
    );

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for inst_valid, checks the latency in negedges and
    // compares the presented word against the head of the scoreboard.
    task automatic esperar_inst(input string tag, input int lat_esp);
        int        k;
        esperado_t e;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!inst_valid && k < 20);
        chequear({tag, "_latencia"}, k, lat_esp);
        chequear({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        chequear({tag, "_cola"}, {31'b0, (cola.size() > 0)}, 32'd1);
        if (cola.size() > 0) begin
            e = cola.pop_front();
            chequear({tag, "_inst"}, inst, e.inst);
            chequear({tag, "_pc"}, {24'b0, inst_pc}, {24'b0, e.pc});
        end
    endtask

    task automatic pulso_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        habilitar = 1'b0;
        salto_en  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic visto;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22;

        // ---- reset state ----
        @(negedge clk);
        chequear("rst_inst",    inst, 32'h0);
        chequear("rst_inst_pc", {24'b0, inst_pc}, 32'h0);
        chequear("rst_valid",   {31'b0, inst_valid}, 32'd0);
        chequear("rst_ocupado", {31'b0, ocupado}, 32'd0);
        chequear("rst_error",   {31'b0, error_alin}, 32'd0);
        chequear("rst_mem_dir", {24'b0, mem_dir}, 32'h0);

        // ---- 1: two back-to-back fetches with ready high ----
        rst_n      = 1'b1;
        habilitar  = 1'b1;
        inst_ready = 1'b1;
        cola.push_back('{inst: 32'h12345678, pc: 8'h00});
        cola.push_back('{inst: 32'hAABBCCDD, pc: 8'h04});
        esperar_inst("t1a", 4);
        chequear("t1_ocupado_val", {31'b0, ocupado}, 32'd1);
        esperar_inst("t1b", 5);
        habilitar = 1'b0;
        @(negedge clk);
        chequear("t1_idle_valid", {31'b0, inst_valid}, 32'd0);
        chequear("t1_idle_dir",   {24'b0, mem_dir}, 32'h08);
        chequear("t1_idle_ocup",  {31'b0, ocupado}, 32'd0);

        // ---- 2: back-pressure in VAL ----
        pulso_reset();
        habilitar  = 1'b1;
        inst_ready = 1'b0;
        cola.push_back('{inst: 32'h12345678, pc: 8'h00});
        esperar_inst("t2a", 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chequear("t2_hold_valid", {31'b0, inst_valid}, 32'd1);
            chequear("t2_hold_inst",  inst, 32'h12345678);
            chequear("t2_hold_dir",   {24'b0, mem_dir}, 32'h00);
        end
        inst_ready = 1'b1;
        cola.push_back('{inst: 32'hAABBCCDD, pc: 8'h04});
        @(negedge clk);
        chequear("t2_next_dir",   {24'b0, mem_dir}, 32'h04);
        chequear("t2_next_valid", {31'b0, inst_valid}, 32'd0);
        esperar_inst("t2b", 4);
        habilitar = 1'b0;
        @(negedge clk);

        // ---- 3: redirect during B2 of the first fetch ----
        pulso_reset();
        habilitar  = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chequear("t3_b2_dir", {24'b0, mem_dir}, 32'h02);
        salto_en  = 1'b1;
        salto_dir = 8'h04;
        @(negedge clk);
        salto_en = 1'b0;
        chequear("t3_valid", {31'b0, inst_valid}, 32'd0);
        chequear("t3_dir",   {24'b0, mem_dir}, 32'h04);
        chequear("t3_ocup",  {31'b0, ocupado}, 32'd0);
        cola.push_back('{inst: 32'hAABBCCDD, pc: 8'h04});
        esperar_inst("t3", 4);
        habilitar = 1'b0;
        @(negedge clk);

        // ---- 4: address wrap at the top of memory ----
        salto_en  = 1'b1;
        salto_dir = 8'hFE;
        habilitar = 1'b1;
        @(negedge clk);
        salto_en = 1'b0;
        chequear("t4_dir_fe", {24'b0, mem_dir}, 32'hFE);
        cola.push_back('{inst: 32'h11221234, pc: 8'hFE});
        @(negedge clk);
        chequear("t4_dir_ff", {24'b0, mem_dir}, 32'hFF);
        @(negedge clk);
        chequear("t4_dir_00", {24'b0, mem_dir}, 32'h00);
        @(negedge clk);
        chequear("t4_dir_01", {24'b0, mem_dir}, 32'h01);
        esperar_inst("t4", 1);
        habilitar = 1'b0;
        @(negedge clk);
        chequear("t4_pc_wrap", {24'b0, mem_dir}, 32'h02);

        // ---- 5: asynchronous reset in the middle of a fetch ----
        habilitar = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chequear("t5_ocup_b2", {31'b0, ocupado}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chequear("t5_inst",    inst, 32'h0);
        chequear("t5_inst_pc", {24'b0, inst_pc}, 32'h0);
        chequear("t5_valid",   {31'b0, inst_valid}, 32'd0);
        chequear("t5_ocup",    {31'b0, ocupado}, 32'd0);
        chequear("t5_dir",     {24'b0, mem_dir}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cola.push_back('{inst: 32'h12345678, pc: 8'h00});
        esperar_inst("t5", 4);
        habilitar = 1'b0;
        @(negedge clk);

        // ---- 6: unaligned redirect ----
        salto_en  = 1'b1;
        salto_dir = 8'h05;
        habilitar = 1'b1;
        @(negedge clk);
        salto_en = 1'b0;
`ifdef CTRL_ALIGN_CHECK_EN
        chequear("t6_error", {31'b0, error_alin}, 32'd1);
        chequear("t6_dir",   {24'b0, mem_dir}, 32'h05);
        visto = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            visto = visto | inst_valid | ocupado;
        end
        chequear("t6_halt", {31'b0, visto}, 32'd0);
        chequear("t6_error_sticky", {31'b0, error_alin}, 32'd1);
`else
        visto = 1'b0;
        chequear("t6_error", {31'b0, error_alin}, 32'd0);
        cola.push_back('{inst: 32'hBBCCDD00, pc: 8'h05});
        esperar_inst("t6", 4);
        chequear("t6_error_after", {31'b0, (error_alin | visto)}, 32'd0);
`endif
        habilitar = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controlador_busqueda.md
Name: controlador_busqueda

Overview:
- Instruction-fetch sequencer placed between the byte-wide instruction memory and the decode stage.
- Owns the program counter (PC) and walks four consecutive byte addresses.
- Assembles each 32-bit big-endian instruction (byte at PC is bits 31:24).
- Hands the instruction to decode over a valid/ready handshake, and accepts redirect (jump/branch) requests that abort any fetch in progress.

Parameters:
ANCHO_DIR, 8, width of PC and memory byte address; all address arithmetic is modulo 2^ANCHO_DIR.
PC_INICIAL, 0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
habilitar  input  1  run enable; sampled only when starting a new fetch.
salto_en  input  1  redirect request, single-cycle pulse or level.
salto_dir  input  ANCHO_DIR  redirect target byte address.
mem_dir  output  ANCHO_DIR  byte address to instruction memory.
mem_dato  input  8  byte returned combinationally for mem_dir in the same cycle.
inst  output  32  assembled instruction.
inst_pc  output  ANCHO_DIR  byte address of inst's first byte.
inst_valid  output  1  inst/inst_pc valid.
inst_ready  input  1  decode accepts inst.
ocupado  output  1  high while in B1..B3 or VAL.
error_alin  output  1  sticky misalignment flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync release):
  - state=B0, pc=PC_INICIAL, shift register=0.
  - inst=0, inst_pc=0, inst_valid=0, ocupado=0, error_alin=0.
- States: B0, B1, B2, B3, VAL.
- mem_dir = pc + k (mod 2^ANCHO_DIR) in state Bk; mem_dir = pc in VAL.
  - mem_dir is a registered-state function only, with no input-to-output path.
- B0:
  - If habilitar=1: capture mem_dato into byte 3 (bits 31:24) and go to B1.
  - Otherwise hold; nothing is captured.
- B1: capture bits 23:16, go to B2. B2: capture bits 15:8, go to B3.
  - In B1..B3, habilitar is ignored and an in-flight fetch always completes.
- B3:
  - Capture bits 7:0.
  - Load inst with the full word and inst_pc=pc.
  - Set inst_valid=1, go to VAL.
- VAL:
  - inst and inst_pc are held stable while inst_ready=0.
  - On inst_valid&inst_ready: inst_valid=0, pc=pc+4 (wraps), go to B0.
- Latency: first inst_valid rises at the 4th rising edge after the first edge with habilitar=1 in B0.
  - With inst_ready tied high, throughput is one instruction per 5 cycles.
- Redirect (salto_en=1) has highest priority in every state:
  - Next edge: pc=salto_dir, state=B0, inst_valid=0, partially captured bytes discarded.
  - If it coincides with a VAL handshake, that instruction counts as accepted, but pc takes salto_dir, not pc+4.
  - salto_en held high keeps reloading pc and holding B0.
- PC wrap: fetches crossing the top address wrap bytes to address 0.
  - Example: pc=0xFE reads FE, FF, 00, 01.
- inst holds its last value when inst_valid=0.
- Reset asserted mid-fetch returns all state to reset values immediately.

Optional Feature:
Macro CTRL_ALIGN_CHECK_EN.
- Defined:
  - A redirect with salto_dir[1:0]≠0 sets error_alin=1; the flag is cleared only by reset.
  - pc is still loaded, but the block stays in B0 and ignores habilitar until reset (halt).
  - Aligned redirects behave normally.
- Undefined:
  - error_alin is constant 0.
  - Unaligned targets are fetched as-is, byte by byte.

Test Plan:
1. Memory bytes 0..7 = 12 34 56 78 AA BB CC DD, PC_INICIAL=0, habilitar=1, inst_ready=1 → inst=0x12345678/inst_pc=0x00 valid on cycle 4, then inst=0xAABBCCDD/inst_pc=0x04 valid 5 cycles later.
2. inst_ready=0 for 3 cycles in VAL → inst_valid stays 1, inst stays 0x12345678, mem_dir stays 0x00; accept on the 4th cycle → next fetch reads address 0x04.
3. salto_en with salto_dir=0x04, pulsed during B2 of the first fetch → no output for address 0; next valid output is inst=0xAABBCCDD, inst_pc=0x04.
4. Wrap: preload m[FE]=11, m[FF]=22; redirect to 0xFE → mem_dir sequence FE, FF, 00, 01; inst=0x11221234, inst_pc=0xFE.
5. rst_n pulsed low during B2 → outputs zero immediately; after release, fetch restarts at PC_INICIAL and produces 0x12345678.
6. With CTRL_ALIGN_CHECK_EN, redirect to 0x05 → error_alin=1, state held in B0, inst_valid stays 0 despite habilitar=1; without the macro, the same stimulus yields inst=0xBBCCDD00 (m[8]=00), inst_pc=0x05.
